// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: bundles the instruction-memory return path, the
// redirect request and the decode-side head/handshake signals of the fetch
// queue. The slave modport is the queue; the master modport is its environment.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic [31:0]            mem_inst;
  logic                   mem_fault;
  logic                   mmu_stall;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   deq_ready;
  logic [31:0]            fetch_pc;
  logic                   out_valid;
  logic [31:0]            out_inst;
  logic [31:0]            out_pc;
  logic                   out_fault;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output mem_inst, mem_fault, mmu_stall, redirect, redirect_pc, deq_ready,
    input  fetch_pc, out_valid, out_inst, out_pc, out_fault, count
  );

  modport slave (
    input  mem_inst, mem_fault, mmu_stall, redirect, redirect_pc, deq_ready,
    output fetch_pc, out_valid, out_inst, out_pc, out_fault, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC owner plus a DEPTH-entry prefetch FIFO between the
// instruction memory port and decode. A fetch fault is queued as a NOP entry
// and parks fetch in HALT until the next redirect.
// Optional feature: define FETCHQ_BYPASS_EN to present the incoming word at
// the head combinationally when the queue is empty (zero-latency fetch).
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  localparam logic [31:0]      NOP_INST   = 32'h0000_0013;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [0:0]       state_q;
  logic [31:0]      pc_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0] inst_mem  [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic        fault_mem [DEPTH];

  logic [31:0] in_inst;
  logic        queue_empty;
  logic        queue_full;
  logic        fetching;
  logic        bypass_active;
  logic        out_valid;
  logic        deq;
  logic        enq;
  logic        bypass_take;
  logic        push;
  logic        pop;

  // A faulting fetch carries a NOP in place of the garbage memory word.
  assign in_inst     = bus.mem_fault ? NOP_INST : bus.mem_inst;
  assign queue_empty = (count_q == '0);
  assign queue_full  = (count_q == FULL_COUNT);
  assign fetching    = (state_q == ST_FETCH) && !bus.mmu_stall && !bus.redirect;

`ifdef FETCHQ_BYPASS_EN
  assign bypass_active = queue_empty && fetching && !rst;
`else
  assign bypass_active = 1'b0;
`endif

  // deq_ready reaches enq only through the full-queue term.
  assign out_valid   = !queue_empty || bypass_active;
  assign deq         = out_valid && bus.deq_ready;
  assign enq         = fetching && (!queue_full || deq);
  assign bypass_take = bypass_active && deq;
  assign push        = enq && !bypass_take;
  assign pop         = deq && !bypass_take;

  assign bus.fetch_pc  = pc_q;
  assign bus.count     = count_q;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = bypass_active ? in_inst       : inst_mem[rd_ptr_q];
  assign bus.out_pc    = bypass_active ? pc_q          : pc_mem[rd_ptr_q];
  assign bus.out_fault = bypass_active ? bus.mem_fault : fault_mem[rd_ptr_q];

  // Pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry storage; reset contents give the NOP/zero head seen after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i]  <= NOP_INST;
        pc_mem[i]    <= '0;
        fault_mem[i] <= 1'b0;
      end
    end else if (push) begin
      inst_mem[wr_ptr_q]  <= in_inst;
      pc_mem[wr_ptr_q]    <= pc_q;
      fault_mem[wr_ptr_q] <= bus.mem_fault;
    end
  end

  // Fetch PC and FETCH/HALT control; a fault freezes the PC on the faulting address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_FETCH;
    end else if (bus.redirect) begin
      pc_q    <= {bus.redirect_pc[31:2], 2'b00};
      state_q <= ST_FETCH;
    end else if (enq) begin
      if (bus.mem_fault) state_q <= ST_HALT;
      else               pc_q    <= pc_q + 32'd4;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: table-driven and directed checks of the fetch queue,
// followed by random traffic compared against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  typedef struct {
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        fault;
    logic        deq_ready;
    logic [31:0] exp_fetch_pc;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic [31:0] exp_out_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int check_count = 0;
  int pass_count  = 0;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: a fixed word per address, special word at 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    if (pc == 32'h0000_0100) return 32'h0050_0093;
    return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
  endfunction

  always_comb bus.mem_inst = mem_word(bus.fetch_pc);

  // Reference model state
  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_bypass, m_valid, m_deq, m_enq;
  entry_t      m_inc;

  logic        cur_redirect, cur_stall, cur_fault, cur_deq_ready;
  logic [31:0] cur_redirect_pc;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    mq.delete();
    m_pc   = RESET_PC;
    m_halt = 1'b0;
  endtask

  task automatic modelCheck();
    entry_t head;
`ifdef FETCHQ_BYPASS_EN
    m_bypass = (mq.size() == 0) && !m_halt && !cur_stall && !cur_redirect;
`else
    m_bypass = 1'b0;
`endif
    m_inc.inst  = cur_fault ? 32'h0000_0013 : mem_word(m_pc);
    m_inc.pc    = m_pc;
    m_inc.fault = cur_fault;
    m_valid = (mq.size() > 0) || m_bypass;
    head    = (mq.size() > 0) ? mq[0] : m_inc;
    m_deq   = m_valid && cur_deq_ready;
    m_enq   = !m_halt && !cur_stall && !cur_redirect && ((mq.size() < DEPTH) || m_deq);
    checkOutput("model_fetch_pc", bus.fetch_pc, m_pc);
    checkOutput("model_out_valid", 32'(bus.out_valid), 32'(m_valid));
    checkOutput("model_count", 32'(bus.count), 32'(mq.size()));
    if (m_valid) begin
      checkOutput("model_out_inst", bus.out_inst, head.inst);
      checkOutput("model_out_pc", bus.out_pc, head.pc);
      checkOutput("model_out_fault", 32'(bus.out_fault), 32'(head.fault));
    end
  endtask

  task automatic modelUpdate();
    bit take;
    if (cur_redirect) begin
      mq.delete();
      m_pc   = {cur_redirect_pc[31:2], 2'b00};
      m_halt = 1'b0;
    end else begin
      take = m_bypass && m_deq;
      if (m_deq && !take) void'(mq.pop_front());
      if (m_enq && !take) mq.push_back(m_inc);
      if (m_enq) begin
        if (cur_fault) m_halt = 1'b1;
        else           m_pc   = m_pc + 32'd4;
      end
    end
  endtask

  // Drive one cycle's inputs at the falling edge and check against the model.
  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic st,
                               input logic flt, input logic dr);
    @(negedge clk);
    cur_redirect = rd; cur_redirect_pc = rpc; cur_stall = st;
    cur_fault = flt; cur_deq_ready = dr;
    bus.redirect = rd; bus.redirect_pc = rpc; bus.mmu_stall = st;
    bus.mem_fault = flt; bus.deq_ready = dr;
    #1;
    modelCheck();
  endtask

  task automatic advance();
    @(posedge clk);
    modelUpdate();
  endtask

  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic st,
                       input logic flt, input logic dr);
    applyStimulus(rd, rpc, st, flt, dr);
    advance();
  endtask

  // Inputs that leave the queue untouched across an unmodelled edge.
  task automatic idleInputs();
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.mmu_stall = 1'b1;
    bus.mem_fault = 1'b0; bus.deq_ready = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 3'd0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 3'd1, 32'h100};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h108, 1'b1, 3'd2, 32'h100};
    vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h10C, 1'b1, 3'd3, 32'h100};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 3'd4, 32'h100};
    vecs[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 3'd4, 32'h100};
    vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 3'd4, 32'h100};
    vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 3'd4, 32'h100};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h110, 1'b1, 3'd4, 32'h100};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h114, 1'b1, 3'd4, 32'h104};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h118, 1'b1, 3'd4, 32'h108};
    vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11C, 1'b1, 3'd4, 32'h10C};
    vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h120, 1'b1, 3'd4, 32'h110};

    idleInputs();
    modelReset();
    #12;
    checkOutput("reset_fetch_pc", bus.fetch_pc, 32'h100);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_count", 32'(bus.count), 32'h0);
    checkOutput("reset_out_inst", bus.out_inst, 32'h13);
    checkOutput("reset_out_pc", bus.out_pc, 32'h0);
    checkOutput("reset_out_fault", 32'(bus.out_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full with decode stalled, then drain with no bubble.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].redirect, vecs[i].redirect_pc, vecs[i].stall, vecs[i].fault, vecs[i].deq_ready);
      checkOutput($sformatf("vec%0d_fetch_pc", i), bus.fetch_pc, vecs[i].exp_fetch_pc);
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].exp_out_pc);
        checkOutput($sformatf("vec%0d_out_inst", i), bus.out_inst, mem_word(vecs[i].exp_out_pc));
      end
      if (i == 1) checkOutput("first_inst", bus.out_inst, 32'h0050_0093);
      advance();
    end

    // MMU stall holds fetch at 0x200 while buffered entries drain.
    cycle(1'b1, 32'h1F8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      checkOutput("stall_fetch_pc", bus.fetch_pc, 32'h200);
      checkOutput("stall_count", 32'(bus.count), 32'(2 - i));
      advance();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("stall_resume_pc", bus.fetch_pc, 32'h200);
    advance();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_resume_head", bus.out_pc, 32'h200);
    advance();

    // Fault at 0x300: NOP entry, HALT, PC frozen, queue stops growing.
    cycle(1'b1, 32'h2F8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("fault_fetch_pc", bus.fetch_pc, 32'h300);
    advance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("halt_count", 32'(bus.count), 32'h3);
      checkOutput("halt_fetch_pc", bus.fetch_pc, 32'h300);
      advance();
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("fault_out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("fault_out_pc", bus.out_pc, 32'h300);
    checkOutput("fault_out_inst", bus.out_inst, 32'h13);
    checkOutput("fault_out_fault", 32'(bus.out_fault), 32'h1);
    advance();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("halt_drained_count", 32'(bus.count), 32'h0);
    checkOutput("halt_drained_pc", bus.fetch_pc, 32'h300);
    advance();

    // Redirect out of HALT with three entries queued.
    cycle(1'b1, 32'h2F8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h8000_0002, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_redirect_count", 32'(bus.count), 32'h3);
    advance();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("redirect_count", 32'(bus.count), 32'h0);
    checkOutput("redirect_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("redirect_fetch_pc", bus.fetch_pc, 32'h8000_0000);
    advance();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("redirect_head_pc", bus.out_pc, 32'h8000_0000);
    advance();

    // PC wraps past the top of the address space.
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_pre_pc", bus.fetch_pc, 32'hFFFF_FFFC);
    advance();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_post_pc", bus.fetch_pc, 32'h0);
    checkOutput("wrap_head_pc", bus.out_pc, 32'hFFFF_FFFC);
    advance();

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(bus.count), 32'h0);
    checkOutput("async_rst_fetch_pc", bus.fetch_pc, RESET_PC);
    checkOutput("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    idleInputs();
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(15) == 0, $urandom, $urandom_range(3) == 0,
            $urandom_range(19) == 0, $urandom_range(9) < 6);
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
